// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (port 0) and load (port 1) writeback.
// Latency: 1 cycle from transfer to rf_write; ready is combinational and dropped by stall or reset.
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [CNT_W-1:0]  collisions
);

    logic              last_q, last_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  coll_q, coll_d;
    logic              grant0, grant1;
    logic              contend;

    assign contend = req0_valid & req1_valid & ~stall;

    // Port 0 wins when alone, or under contention when port 1 had the last grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !stall) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        last_d     = last_q;
        rf_write_d = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        coll_d     = coll_q;
        if (grant0) begin
            last_d     = 1'b0;
            rf_write_d = (req0_addr != '0);
            rf_waddr_d = req0_addr;
            rf_wdata_d = req0_data;
        end else if (grant1) begin
            last_d     = 1'b1;
            rf_write_d = (req1_addr != '0);
            rf_waddr_d = req1_addr;
            rf_wdata_d = req1_data;
        end
        if (contend && (coll_q != {CNT_W{1'b1}})) begin
            coll_d = coll_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            coll_q     <= '0;
        end else begin
            last_q     <= last_d;
            rf_write_q <= rf_write_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            coll_q     <= coll_d;
        end
    end

    assign rf_write   = rf_write_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pend_valid = rf_write_q;
    assign pend_addr  = rf_waddr_q;
    assign collisions = coll_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, random traffic against a model, counter saturation.
module tb_regfile_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, stall;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, rf_write, pend_valid;
    logic [AW-1:0] rf_waddr, pend_addr;
    logic [DW-1:0] rf_wdata;
    logic [15:0]   collisions;

    logic          s_req0_ready, s_req1_ready, s_rf_write, s_pend_valid;
    logic [AW-1:0] s_rf_waddr, s_pend_addr;
    logic [DW-1:0] s_rf_wdata;
    logic [3:0]    s_collisions;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .collisions(collisions)
    );

    regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_req1_ready),
        .rf_write(s_rf_write), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .pend_valid(s_pend_valid), .pend_addr(s_pend_addr), .collisions(s_collisions)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          stl;
        bit          v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        bit          r0;
        bit          r1;
        bit          w;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          coll;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit stl,
                       input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit r0, input bit r1, input bit w,
                       input logic [4:0] wa, input logic [31:0] wd, input int coll);
        vec_t v;
        v.rst = rst; v.stl = stl; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
        v.w = w; v.wa = wa; v.wd = wd; v.coll = coll;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit rst, input bit stl,
                         input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        rst_n = rst; stall = stl;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Random-phase reference: preferred port under contention, expected write port state, counters.
    int          pref;
    bit          m_w;
    logic [4:0]  m_a;
    logic [31:0] m_d;
    int          m_coll, m_scoll;
    bit          hold0, hold1;

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

        //  rst stl v0 a0  d0           v1 a1  d1          r0 r1 w  wa  wd           coll
        add(0, 0, 1, 7,  32'h1,        1, 8,  32'h2,      0, 0, 0, 0,  32'h0,        0);
        add(0, 0, 1, 7,  32'h1,        1, 8,  32'h2,      0, 0, 0, 0,  32'h0,        0);
        add(1, 0, 1, 3,  32'h33,       1, 9,  32'h99,     1, 0, 1, 3,  32'h33,       1);
        add(1, 0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,      1, 0, 1, 5,  32'hDEADBEEF, 1);
        add(1, 0, 0, 0,  32'h0,        0, 0,  32'h0,      0, 0, 0, 5,  32'hDEADBEEF, 1);
        add(1, 0, 0, 0,  32'h0,        1, 20, 32'h2020,   0, 1, 1, 20, 32'h2020,     1);
        add(1, 0, 1, 1,  32'h101,      1, 11, 32'h20B,    1, 0, 1, 1,  32'h101,      2);
        add(1, 0, 1, 2,  32'h102,      1, 11, 32'h20B,    0, 1, 1, 11, 32'h20B,      3);
        add(1, 0, 1, 2,  32'h102,      1, 12, 32'h20C,    1, 0, 1, 2,  32'h102,      4);
        add(1, 0, 1, 3,  32'h103,      1, 12, 32'h20C,    0, 1, 1, 12, 32'h20C,      5);
        add(1, 0, 0, 0,  32'h0,        0, 0,  32'h0,      0, 0, 0, 12, 32'h20C,      5);
        add(1, 1, 1, 3,  32'h103,      1, 13, 32'h20D,    0, 0, 0, 12, 32'h20C,      5);
        add(1, 1, 1, 3,  32'h103,      1, 13, 32'h20D,    0, 0, 0, 12, 32'h20C,      5);
        add(1, 1, 1, 3,  32'h103,      1, 13, 32'h20D,    0, 0, 0, 12, 32'h20C,      5);
        add(1, 0, 1, 3,  32'h103,      1, 13, 32'h20D,    1, 0, 1, 3,  32'h103,      6);
        add(1, 0, 1, 4,  32'h104,      1, 13, 32'h20D,    0, 1, 1, 13, 32'h20D,      7);
        add(1, 1, 1, 4,  32'h104,      1, 14, 32'h20E,    0, 0, 0, 13, 32'h20D,      7);
        add(1, 0, 1, 6,  32'h106,      0, 0,  32'h0,      1, 0, 1, 6,  32'h106,      7);
        add(1, 0, 0, 0,  32'h0,        1, 0,  32'h1234,   0, 1, 0, 0,  32'h1234,     7);
        add(1, 0, 1, 4,  32'h104,      1, 14, 32'h20E,    1, 0, 1, 4,  32'h104,      8);
        add(1, 0, 1, 7,  32'h107,      1, 14, 32'h20E,    0, 1, 1, 14, 32'h20E,      9);
        add(0, 1, 1, 7,  32'h107,      1, 15, 32'h20F,    0, 0, 0, 0,  32'h0,        0);
        add(1, 0, 0, 0,  32'h0,        0, 0,  32'h0,      0, 0, 0, 0,  32'h0,        0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].stl, tbl[i].v0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("vec%0d ready0", i), {31'b0, req0_ready}, {31'b0, tbl[i].r0});
            chk($sformatf("vec%0d ready1", i), {31'b0, req1_ready}, {31'b0, tbl[i].r1});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rf_write", i), {31'b0, rf_write}, {31'b0, tbl[i].w});
            chk($sformatf("vec%0d pend_valid", i), {31'b0, pend_valid}, {31'b0, tbl[i].w});
            chk($sformatf("vec%0d rf_waddr", i), {27'b0, rf_waddr}, {27'b0, tbl[i].wa});
            chk($sformatf("vec%0d pend_addr", i), {27'b0, pend_addr}, {27'b0, tbl[i].wa});
            chk($sformatf("vec%0d rf_wdata", i), rf_wdata, tbl[i].wd);
            chk($sformatf("vec%0d collisions", i), {16'b0, collisions}, tbl[i].coll);
        end

        // Table ends with a reset, so the model starts from reset state.
        pref = 0; m_w = 0; m_a = '0; m_d = '0; m_coll = 0; m_scoll = 0;
        hold0 = 0; hold1 = 0;
        for (int c = 0; c < 2000; c++) begin
            bit          rst, stl, v0, v1;
            logic [4:0]  a0, a1;
            logic [31:0] d0, d1;
            int          win;
            @(negedge clk);
            rst = ($urandom_range(0, 99) != 0);
            stl = ($urandom_range(0, 4) == 0);
            if (hold0) begin
                v0 = req0_valid; a0 = req0_addr; d0 = req0_data;
            end else begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = 5'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (hold1) begin
                v1 = req1_valid; a1 = req1_addr; d1 = req1_data;
            end else begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            end
            drive(rst, stl, v0, a0, d0, v1, a1, d1);

            win = -1;
            if (rst && !stl) begin
                if (v0 && v1) win = pref;
                else if (v0)  win = 0;
                else if (v1)  win = 1;
            end
            #1;
            chk("rand ready0", {31'b0, req0_ready}, {31'b0, (win == 0)});
            chk("rand ready1", {31'b0, req1_ready}, {31'b0, (win == 1)});

            if (!rst) begin
                pref = 0; m_w = 0; m_a = '0; m_d = '0; m_coll = 0; m_scoll = 0;
            end else begin
                m_w = 0;
                if (win >= 0) begin
                    m_a  = (win == 0) ? a0 : a1;
                    m_d  = (win == 0) ? d0 : d1;
                    m_w  = (m_a != 0);
                    pref = 1 - win;
                end
                if (v0 && v1 && !stl) begin
                    m_coll  = (m_coll  < 65535) ? m_coll + 1  : m_coll;
                    m_scoll = (m_scoll < 15)    ? m_scoll + 1 : m_scoll;
                end
            end
            hold0 = v0 && (win != 0);
            hold1 = v1 && (win != 1);

            @(posedge clk);
            #1;
            chk("rand rf_write", {31'b0, rf_write}, {31'b0, m_w});
            chk("rand pend_addr", {27'b0, pend_addr}, {27'b0, m_a});
            chk("rand rf_wdata", rf_wdata, m_d);
            chk("rand collisions", {16'b0, collisions}, m_coll);
            chk("rand small collisions", {28'b0, s_collisions}, m_scoll);
        end

        // Saturation of a 4-bit counter over 20 contended cycles.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, 5'(k), 32'(k), 1'b1, 5'(k + 1), 32'(k + 100));
            @(posedge clk);
            #1;
            chk($sformatf("sat cycle%0d small", k), {28'b0, s_collisions}, (k < 15) ? k : 15);
            chk($sformatf("sat cycle%0d wide", k), {16'b0, collisions}, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
